axis_to_vid_out_24b: RTL and testbench

Converts a 24-bit AXI4-Stream video stream back into parallel video, the transmit-side counterpart of the video-in bridge. Pixels are buffered in a small FIFO and released one per cycle under `vtg_active_video` from an external timing generator. Stream SOF (`tuser`) is aligned to the first active pixel of a frame. Loss of alignment or FIFO underflow forces a resynchronisation. The block sits between the VDMA read channel (MM2S) and the HDMI/TMDS encoder, all in the video clock domain.

---
 rtl/vid_out_pkg.sv | 22 ++
 rtl/vid_out_fifo.sv | 60 ++++++
 rtl/axis_to_vid_out_24b.sv | 162 ++++++++++++++++
 tb/tb_axis_to_vid_out_24b.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_out_pkg.sv
// Shared types and entry-layout helpers for the AXI4-Stream to parallel video bridge.
package vid_out_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // A FIFO entry is {tuser, tlast, tdata}.
  function automatic int entry_w(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int tuser_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int tlast_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/vid_out_fifo.sv
// First-word-fall-through pixel FIFO; rd_data always shows the head entry.
module vid_out_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // full is held high through reset so the upstream sees no ready until the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
    end
  end

endmodule

// File: rtl/axis_to_vid_out_24b.sv
// Releases buffered AXI4-Stream pixels under external video timing, aligning stream SOF
// to the first active pixel of each frame and resynchronising on underflow or misalignment.
module axis_to_vid_out_24b
  import vid_out_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    vclk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    vtg_vblank,
  input  logic                    vtg_vsync,
  input  logic                    vtg_hblank,
  input  logic                    vtg_hsync,
  input  logic                    vtg_active_video,
  input  logic                    vtg_field_id,
  output logic                    vid_vblank,
  output logic                    vid_vsync,
  output logic                    vid_hblank,
  output logic                    vid_hsync,
  output logic                    vid_active_video,
  output logic                    vid_field_id,
  output logic [DATA_WIDTH-1:0]   vid_data,
  output logic                    locked,
  output logic                    underflow,
  output logic                    eol_err
);

  localparam int EW = entry_w(DATA_WIDTH);
  localparam int UB = tuser_bit(DATA_WIDTH);
  localparam int LB = tlast_bit(DATA_WIDTH);

  logic [EW-1:0]              head;
  logic                       full;
  logic                       empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       pop;
  logic                       head_user;
  logic                       head_last;
  logic [DATA_WIDTH-1:0]      head_data;

  state_t                     state;
  state_t                     state_nxt;
  logic [DATA_WIDTH-1:0]      pix_nxt;
  logic                       uf_nxt;
  logic                       good_pix;
  logic                       vsync_p1;
  logic                       frame_pending;
  logic                       fp;
  logic                       vld_p1;
  logic                       last_p1;
  logic                       unused_bits;

  assign unused_bits = ^{s_axis_tkeep, fifo_count};

  vid_out_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (vclk),
    .rst_n   (resetn),
    .wr_en   (s_axis_tvalid),
    .wr_data ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign s_axis_tready = !full;
  assign head_user     = head[UB];
  assign head_last     = head[LB];
  assign head_data     = head[DATA_WIDTH-1:0];
  assign fp            = vtg_active_video && frame_pending;
  assign locked        = (state == LOCKED);

  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    pix_nxt   = '0;
    uf_nxt    = 1'b0;
    good_pix  = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (!empty) begin
          if (!head_user) begin
            pop = 1'b1;
          end else if (fp) begin
            pop       = 1'b1;
            pix_nxt   = head_data;
            good_pix  = 1'b1;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (vtg_active_video) begin
          if (empty) begin
            uf_nxt    = 1'b1;
            state_nxt = WAIT_SOF;
          end else begin
            pop = 1'b1;
            // SOF must coincide exactly with the frame's first pixel.
            if (head_user != fp) begin
              state_nxt = WAIT_SOF;
            end else begin
              pix_nxt  = head_data;
              good_pix = 1'b1;
            end
          end
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // Stage p1: registered timing, pixel and status; line-end check of the previous pixel.
  always_ff @(posedge vclk or negedge resetn) begin
    if (!resetn) begin
      state            <= WAIT_SOF;
      vsync_p1         <= 1'b0;
      frame_pending    <= 1'b0;
      vld_p1           <= 1'b0;
      vid_vblank       <= 1'b0;
      vid_vsync        <= 1'b0;
      vid_hblank       <= 1'b0;
      vid_hsync        <= 1'b0;
      vid_active_video <= 1'b0;
      vid_field_id     <= 1'b0;
      vid_data         <= '0;
      underflow        <= 1'b0;
      eol_err          <= 1'b0;
    end else begin
      state            <= state_nxt;
      vsync_p1         <= vtg_vsync;
      if (vtg_vsync && !vsync_p1) frame_pending <= 1'b1;
      else if (vtg_active_video)  frame_pending <= 1'b0;
      vld_p1           <= good_pix;
      vid_vblank       <= vtg_vblank;
      vid_vsync        <= vtg_vsync;
      vid_hblank       <= vtg_hblank;
      vid_hsync        <= vtg_hsync;
      vid_active_video <= vtg_active_video;
      vid_field_id     <= vtg_field_id;
      vid_data         <= pix_nxt;
      underflow        <= uf_nxt;
      eol_err          <= vld_p1 && (last_p1 == vtg_active_video);
    end
  end

  always_ff @(posedge vclk) begin
    last_p1 <= head_last;
  end

endmodule

// File: tb/tb_axis_to_vid_out_24b.sv
// Directed bench for axis_to_vid_out_24b: a vector table for the nominal frame plus
// hand-written sequences for garbage, underflow, backpressure, misalignment and reset.
module tb_axis_to_vid_out_24b;

  logic        vclk = 1'b0;
  logic        resetn = 1'b1;
  logic [23:0] s_axis_tdata = '0;
  logic [2:0]  s_axis_tkeep = 3'b111;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        vtg_vblank = 1'b0, vtg_vsync = 1'b0, vtg_hblank = 1'b0;
  logic        vtg_hsync = 1'b0, vtg_active_video = 1'b0, vtg_field_id = 1'b0;
  logic        vid_vblank, vid_vsync, vid_hblank, vid_hsync, vid_active_video, vid_field_id;
  logic [23:0] vid_data;
  logic        locked, underflow, eol_err;

  always #5 vclk = ~vclk;

  axis_to_vid_out_24b #(.DATA_WIDTH(24), .FIFO_DEPTH(32)) dut (
    .vclk             (vclk),
    .resetn           (resetn),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .vtg_vblank       (vtg_vblank),
    .vtg_vsync        (vtg_vsync),
    .vtg_hblank       (vtg_hblank),
    .vtg_hsync        (vtg_hsync),
    .vtg_active_video (vtg_active_video),
    .vtg_field_id     (vtg_field_id),
    .vid_vblank       (vid_vblank),
    .vid_vsync        (vid_vsync),
    .vid_hblank       (vid_hblank),
    .vid_hsync        (vid_hsync),
    .vid_active_video (vid_active_video),
    .vid_field_id     (vid_field_id),
    .vid_data         (vid_data),
    .locked           (locked),
    .underflow        (underflow),
    .eol_err          (eol_err)
  );

  typedef struct packed {
    logic        u;
    logic        l;
    logic [23:0] d;
  } word_t;

  typedef struct {
    logic        vs;
    logic        act;
    logic        e_act;
    logic [23:0] e_data;
    logic        e_lock;
  } vec_t;

  word_t       src_q[$];
  logic [23:0] pix_q[$];
  logic        lock_q[$];
  logic [23:0] exp_pix_q[$];
  logic        exp_lock_q[$];
  vec_t        vecs[13];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          uf_cnt = 0;
  int          eol_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step_cycle(input logic vs, input logic act, input logic hs, input logic vb);
    logic acc;
    vtg_vsync        = vs;
    vtg_vblank       = vb;
    vtg_hsync        = hs;
    vtg_hblank       = !act;
    vtg_active_video = act;
    vtg_field_id     = 1'b0;
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0].d;
      s_axis_tuser  = src_q[0].u;
      s_axis_tlast  = src_q[0].l;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
    end
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge vclk);
    #1;
    if (acc) begin
      src_q.delete(0);
      acc_cnt++;
    end
    if (vid_active_video) begin
      pix_q.push_back(vid_data);
      lock_q.push_back(locked);
    end
    if (underflow) uf_cnt++;
    if (eol_err) eol_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int w, input int h);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic add_words(input int base, input int n, input logic [63:0] umask,
                           input logic [63:0] lmask);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.u = umask[i];
      w.l = lmask[i];
      w.d = 24'(base + i);
      src_q.push_back(w);
    end
  endtask

  task automatic clear_obs();
    pix_q.delete();
    lock_q.delete();
    acc_cnt = 0;
    uf_cnt  = 0;
    eol_cnt = 0;
  endtask

  task automatic set_exp(input int base, input int ngood, input int ntotal);
    exp_pix_q.delete();
    exp_lock_q.delete();
    for (int i = 0; i < ntotal; i++) begin
      exp_pix_q.push_back(i < ngood ? 24'(base + i) : 24'd0);
      exp_lock_q.push_back(i < ngood);
    end
  endtask

  task automatic compare_frame(input string name);
    chk({name, "_npix"}, pix_q.size(), exp_pix_q.size());
    for (int i = 0; i < exp_pix_q.size() && i < pix_q.size(); i++) begin
      chk($sformatf("%s_pix%0d", name, i), pix_q[i], exp_pix_q[i]);
      chk($sformatf("%s_lock%0d", name, i), lock_q[i], exp_lock_q[i]);
    end
  endtask

  task automatic reset_dut();
    src_q.delete();
    s_axis_tvalid = 1'b0;
    vtg_vsync = 1'b0; vtg_vblank = 1'b0; vtg_hsync = 1'b0;
    vtg_hblank = 1'b0; vtg_active_video = 1'b0;
    resetn = 1'b0;
    @(posedge vclk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic setv(input int k, input logic vs, input logic act, input logic e_act,
                      input logic [23:0] e_data, input logic e_lock);
    vecs[k].vs = vs; vecs[k].act = act; vecs[k].e_act = e_act;
    vecs[k].e_data = e_data; vecs[k].e_lock = e_lock;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Nominal 4x2 frame: outputs follow inputs by one cycle, lock rises on the first pixel.
    setv(0,  1'b1, 1'b0, 1'b0, 24'd0, 1'b0);
    setv(1,  1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    setv(2,  1'b0, 1'b1, 1'b1, 24'd1, 1'b1);
    setv(3,  1'b0, 1'b1, 1'b1, 24'd2, 1'b1);
    setv(4,  1'b0, 1'b1, 1'b1, 24'd3, 1'b1);
    setv(5,  1'b0, 1'b1, 1'b1, 24'd4, 1'b1);
    setv(6,  1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    setv(7,  1'b0, 1'b1, 1'b1, 24'd5, 1'b1);
    setv(8,  1'b0, 1'b1, 1'b1, 24'd6, 1'b1);
    setv(9,  1'b0, 1'b1, 1'b1, 24'd7, 1'b1);
    setv(10, 1'b0, 1'b1, 1'b1, 24'd8, 1'b1);
    setv(11, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    setv(12, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1);

    #1 resetn = 1'b0;
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_vid_data", vid_data, 0);
    chk("rst_vid_act", vid_active_video, 0);
    chk("rst_locked", locked, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_eol", eol_err, 0);
    repeat (2) @(posedge vclk);
    #1 resetn = 1'b1;
    chk("tready_before_edge", s_axis_tready, 0);
    @(posedge vclk);
    #1;
    chk("tready_after_edge", s_axis_tready, 1);

    add_words(1, 8, 64'h1, 64'h88);
    idle(10);
    clear_obs();
    for (int k = 0; k < 13; k++) begin
      step_cycle(vecs[k].vs, vecs[k].act, 1'b0, vecs[k].vs);
      chk($sformatf("nom_act%0d", k), vid_active_video, vecs[k].e_act);
      chk($sformatf("nom_data%0d", k), vid_data, vecs[k].e_data);
      chk($sformatf("nom_lock%0d", k), locked, vecs[k].e_lock);
      chk($sformatf("nom_vsync%0d", k), vid_vsync, vecs[k].vs);
      chk($sformatf("nom_hblank%0d", k), vid_hblank, !vecs[k].act);
      chk($sformatf("nom_uf%0d", k), underflow, 0);
      chk($sformatf("nom_eol%0d", k), eol_err, 0);
    end

    // Leading words without SOF are discarded.
    reset_dut();
    add_words(24'hAA0000, 3, 64'h0, 64'h0);
    add_words(1, 8, 64'h1, 64'h88);
    idle(14);
    clear_obs();
    frame(4, 2);
    set_exp(1, 8, 8);
    compare_frame("garbage");
    chk("garbage_uf", uf_cnt, 0);
    chk("garbage_eol", eol_cnt, 0);

    // Underflow after pixel 5, then relock on the next frame.
    reset_dut();
    add_words(1, 5, 64'h1, 64'h8);
    idle(8);
    clear_obs();
    frame(4, 2);
    set_exp(1, 5, 8);
    compare_frame("uflow");
    chk("uflow_pulses", uf_cnt, 1);
    chk("uflow_eol", eol_cnt, 0);
    chk("uflow_unlocked", locked, 0);
    add_words(1, 8, 64'h1, 64'h88);
    idle(10);
    clear_obs();
    frame(4, 2);
    set_exp(1, 8, 8);
    compare_frame("relock");
    chk("relock_uf", uf_cnt, 0);

    // Backpressure: 40 words against a 32-deep buffer, drained by one 40-pixel line.
    reset_dut();
    add_words(1, 40, 64'h1, 64'd1 << 39);
    idle(45);
    chk("bp_accepted", acc_cnt, 32);
    chk("bp_tready_low", s_axis_tready, 0);
    clear_obs();
    frame(40, 1);
    set_exp(1, 40, 40);
    compare_frame("bp");
    chk("bp_rest_accepted", acc_cnt, 8);
    chk("bp_uf", uf_cnt, 0);
    chk("bp_eol", eol_cnt, 0);

    // SOF on pixel 3 drops lock.
    reset_dut();
    add_words(1, 8, 64'h5, 64'h88);
    idle(10);
    clear_obs();
    frame(4, 2);
    set_exp(1, 2, 8);
    compare_frame("sof3");
    chk("sof3_uf", uf_cnt, 0);
    chk("sof3_eol", eol_cnt, 0);

    // Early tlast on pixel 2 flags but keeps lock.
    reset_dut();
    add_words(1, 8, 64'h1, 64'h8A);
    idle(10);
    clear_obs();
    frame(4, 2);
    set_exp(1, 8, 8);
    compare_frame("eol2");
    chk("eol2_pulses", eol_cnt, 1);
    chk("eol2_uf", uf_cnt, 0);

    // Missing tlast on the last pixel of line 1.
    reset_dut();
    add_words(1, 8, 64'h1, 64'h80);
    idle(10);
    clear_obs();
    frame(4, 2);
    set_exp(1, 8, 8);
    compare_frame("noeol");
    chk("noeol_pulses", eol_cnt, 1);

    // Reset asserted during pixel 4.
    reset_dut();
    add_words(1, 8, 64'h1, 64'h88);
    idle(10);
    clear_obs();
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_locked_before", locked, 1);
    chk("mid_data_before", vid_data, 3);
    vtg_active_video = 1'b1;
    vtg_hblank = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_vid_data", vid_data, 0);
    chk("mid_vid_act", vid_active_video, 0);
    chk("mid_locked", locked, 0);
    chk("mid_tready", s_axis_tready, 0);
    chk("mid_fifo_count", dut.u_fifo.count, 0);
    @(posedge vclk);
    #1;
    resetn = 1'b1;
    vtg_active_video = 1'b0;
    add_words(24'h100, 8, 64'h1, 64'h88);
    idle(10);
    clear_obs();
    frame(4, 2);
    set_exp(24'h100, 8, 8);
    compare_frame("after_rst");
    chk("after_rst_uf", uf_cnt, 0);
    chk("after_rst_eol", eol_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
